// File: rtl/rv_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: state encodings and index-width helper.
package rv_rr_arbiter_pkg;

    localparam logic RV_ARB_STATE_OPEN = 1'b0;
    localparam logic RV_ARB_STATE_HOLD = 1'b1;

    typedef enum logic {
        StOpen = RV_ARB_STATE_OPEN,
        StHold = RV_ARB_STATE_HOLD
    } rv_arb_state_e;

    // $clog2 with a floor of 1 so single-entry vectors still get a legal index port.
    function automatic int unsigned rv_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv_onehot_encoder.sv
// One-hot to binary encoder; MODEL 2 ORs the indices of all set bits, other models pick the highest.
module rv_onehot_encoder
    import rv_rr_arbiter_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned MODEL   = 2,
    parameter bit          REVERSE = 1'b0,
    parameter int unsigned LN      = rv_idx_width(N)
) (
    input  logic [N-1:0]  data_in,
    output logic [LN-1:0] data_out,
    output logic          valid_out
);

    assign valid_out = |data_in;

    if (MODEL == 2) begin : g_or_model
        always_comb begin
            data_out = '0;
            for (int i = 0; i < int'(N); i++) begin
                if (data_in[i]) begin
                    data_out = data_out | (REVERSE ? LN'(int'(N) - 1 - i) : LN'(i));
                end
            end
        end
    end else begin : g_prio_model
        always_comb begin
            data_out = '0;
            for (int i = 0; i < int'(N); i++) begin
                if (data_in[i]) begin
                    data_out = REVERSE ? LN'(int'(N) - 1 - i) : LN'(i);
                end
            end
        end
    end

endmodule

// File: rtl/rv_rr_arbiter.sv
// Round-robin arbiter with valid/ready grant handshake; priority rotates only on accepted grants
// and an optional lock holds a stalled grant stable until it is accepted or its requester drops.
module rv_rr_arbiter
    import rv_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQS     = 4,
    parameter bit          LOCK_ENABLE  = 1'b1,
    parameter int unsigned LOG_NUM_REQS = rv_idx_width(NUM_REQS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQS-1:0]     requests,
    input  logic                    grant_ready,
    output logic                    grant_valid,
    output logic [NUM_REQS-1:0]     grant_onehot,
    output logic [LOG_NUM_REQS-1:0] grant_index
);

    logic enc_valid;

    assign grant_valid = |requests;

    if (NUM_REQS == 1) begin : g_single
        logic unused_ready;
        assign unused_ready = grant_ready;
        assign grant_onehot = requests;
    end else begin : g_multi
        rv_arb_state_e               state_q, state_d;
        logic [NUM_REQS-1:0]         held_q, held_d;
        logic [LOG_NUM_REQS-1:0]     last_q, last_d;
        logic [2*NUM_REQS-1:0]       req_dbl, pick_dbl;
        logic [NUM_REQS-1:0]         rot_onehot;
        logic                        hold_hit;
        logic                        found;

        assign req_dbl = {requests, requests};

        // Scanning the doubled vector above last_q covers last_q+1 .. last_q+NUM_REQS exactly once,
        // so folding the halves wraps at NUM_REQS rather than at a power of two.
        always_comb begin
            pick_dbl = '0;
            found    = 1'b0;
            for (int j = 0; j < 2 * int'(NUM_REQS); j++) begin
                if (!found && req_dbl[j] && (j > int'(last_q))) begin
                    found       = 1'b1;
                    pick_dbl[j] = 1'b1;
                end
            end
        end

        assign rot_onehot   = pick_dbl[NUM_REQS-1:0] | pick_dbl[2*NUM_REQS-1:NUM_REQS];
        assign hold_hit     = (state_q == StHold) && (|(requests & held_q));
        assign grant_onehot = hold_hit ? held_q : rot_onehot;

        always_comb begin
            state_d = state_q;
            held_d  = held_q;
            last_d  = last_q;
            if (grant_valid && grant_ready) begin
                last_d  = grant_index;
                state_d = StOpen;
            end else if (grant_valid && LOCK_ENABLE) begin
                // Also covers a held drop that stalls on the new winner: the lock moves to it.
                state_d = StHold;
                held_d  = grant_onehot;
            end else if (!grant_valid) begin
                state_d = StOpen;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                last_q  <= LOG_NUM_REQS'(NUM_REQS - 1);
                state_q <= StOpen;
                held_q  <= '0;
            end else begin
                last_q  <= last_d;
                state_q <= state_d;
                held_q  <= held_d;
            end
        end
    end

    rv_onehot_encoder #(
        .N       (NUM_REQS),
        .MODEL   (2),
        .REVERSE (1'b0),
        .LN      (LOG_NUM_REQS)
    ) u_encoder (
        .data_in   (grant_onehot),
        .data_out  (grant_index),
        .valid_out (enc_valid)
    );

    a_enc_valid : assert property (@(posedge clk) disable iff (!reset) enc_valid == grant_valid);

endmodule
